// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank,
// line/frame strobes and a frame counter, all derived from the next counter state.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    // Window bounds are one bit wider than the counters so an end bound of
    // exactly 2048 (or 1024) does not wrap to zero.
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL < 1 || H_TOTAL > 2048) begin : g_h_total_check
        $error("vga_timing_gen: H_TOTAL must be in 1..2048");
    end
    if (V_TOTAL < 1 || V_TOTAL > 1024) begin : g_v_total_check
        $error("vga_timing_gen: V_TOTAL must be in 1..1024");
    end

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic        hsync_next;
    logic        vsync_next;
    logic        blank_next;

    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vcount + 10'd1;
        end
        hsync_next = (({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END))
                     ? SYNC_POL : ~SYNC_POL;
        vsync_next = (({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END))
                     ? SYNC_POL : ~SYNC_POL;
        blank_next = ({1'b0, h_next} >= H_ACT_END) || ({1'b0, v_next} >= V_ACT_END);
    end

    // Strobes are cleared on idle clocks so they stay one clk wide at any enable duty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcount      <= 11'd0;
            vcount      <= 10'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else if (enable) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            blank       <= blank_next;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced raster checked every clk against an
// arithmetic model, plus a 1x1 raster that drives frame_count through its wrap.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;   // H_TOTAL 25, hsync 18..20
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;   // V_TOTAL 13, vsync 9..10
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank, line_start, frame_start;
    logic [15:0] frame_count;

    logic        w_reset_n, w_enable;
    logic [10:0] w_hcount;
    logic [9:0]  w_vcount;
    logic        w_hsync, w_vsync, w_blank, w_line_start, w_frame_start;
    logic [15:0] w_frame_count;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .blank(blank), .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    // One pixel per line and one line per frame: a frame_start every enabled clk.
    vga_timing_gen #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_POL(1'b0)
    ) dut_wrap (
        .clk(clk), .reset_n(w_reset_n), .enable(w_enable),
        .hcount(w_hcount), .vcount(w_vcount), .hsync(w_hsync), .vsync(w_vsync),
        .blank(w_blank), .line_start(w_line_start), .frame_start(w_frame_start),
        .frame_count(w_frame_count)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit bl;
        int fc;
    } exp_t;

    // Everything follows from n = enabled edges since reset.
    function automatic exp_t model(input longint n, input int ha, input int hf,
                                   input int hs, input int hb, input int va,
                                   input int vf, input int vs, input int vb);
        exp_t   e;
        longint ht = ha + hf + hs + hb;
        longint vt = va + vf + vs + vb;
        e.h  = int'(n % ht);
        e.v  = int'((n / ht) % vt);
        e.hs = !(e.h >= ha + hf && e.h < ha + hf + hs);
        e.vs = !(e.v >= va + vf && e.v < va + vf + vs);
        e.bl = (e.h >= ha) || (e.v >= va);
        e.fc = int'((n / (ht * vt)) % 65536);
        return e;
    endfunction

    longint m_n = 0, w_n = 0;
    bit     m_en = 0, w_en = 0;
    bit     m_chk = 0, w_chk = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_n  <= 0;
            m_en <= 0;
        end else begin
            if (enable) m_n <= m_n + 1;
            m_en <= enable;
        end
        if (!w_reset_n) begin
            w_n  <= 0;
            w_en <= 0;
        end else begin
            if (w_enable) w_n <= w_n + 1;
            w_en <= w_enable;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_chk) begin
            e = model(m_n, HA, HF, HS, HB, VA, VF, VS, VB);
            check("hcount", 32'(hcount), e.h);
            check("vcount", 32'(vcount), e.v);
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("blank", 32'(blank), 32'(e.bl));
            check("frame_count", 32'(frame_count), e.fc);
            check("line_start", 32'(line_start), 32'(m_en && (m_n % HT == 0)));
            check("frame_start", 32'(frame_start), 32'(m_en && (m_n % (HT * VT) == 0)));
        end
        if (w_chk) begin
            e = model(w_n, 1, 0, 0, 0, 1, 0, 0, 0);
            check("w_hcount", 32'(w_hcount), e.h);
            check("w_vcount", 32'(w_vcount), e.v);
            check("w_hsync", 32'(w_hsync), 32'(e.hs));
            check("w_vsync", 32'(w_vsync), 32'(e.vs));
            check("w_blank", 32'(w_blank), 32'(e.bl));
            check("w_frame_count", 32'(w_frame_count), e.fc);
            check("w_line_start", 32'(w_line_start), 32'(w_en));
            check("w_frame_start", 32'(w_frame_start), 32'(w_en));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_reset_state(input string tag);
        check({tag, "_hcount"}, 32'(hcount), 0);
        check({tag, "_vcount"}, 32'(vcount), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_blank"}, 32'(blank), 0);
        check({tag, "_frame_count"}, 32'(frame_count), 0);
        check({tag, "_line_start"}, 32'(line_start), 0);
        check({tag, "_frame_start"}, 32'(frame_start), 0);
    endtask

    // ---------------- main raster sequence ----------------
    logic [31:0] exp_q[$];

    task automatic run_main();
        int  pulses = 0;
        int  wide   = 0;
        int  prev_i = -1;
        bit  prev   = 0;

        reset_n = 1'b0;
        enable  = 1'b1;
        tick(3);
        expect_reset_state("reset");
        m_chk   = 1;
        reset_n = 1'b1;

        // Horizontal window, literal pins on the model.
        tick(20);
        check("h20_hcount", 32'(hcount), 20);
        check("h20_hsync", 32'(hsync), 0);
        check("h20_blank", 32'(blank), 1);
        tick(1);
        check("h21_hsync", 32'(hsync), 1);
        tick(4);
        check("wrap_hcount", 32'(hcount), 0);
        check("wrap_vcount", 32'(vcount), 1);
        check("wrap_line_start", 32'(line_start), 1);
        check("wrap_frame_start", 32'(frame_start), 0);
        tick(1);
        check("after_wrap_line_start", 32'(line_start), 0);

        // Vertical window and frame wrap.
        tick(199);
        check("v9_vcount", 32'(vcount), 9);
        check("v9_vsync", 32'(vsync), 0);
        tick(75);
        check("v12_vcount", 32'(vcount), 12);
        check("v12_vsync", 32'(vsync), 1);
        check("v12_blank", 32'(blank), 1);
        tick(25);
        check("f1_frame_start", 32'(frame_start), 1);
        check("f1_frame_count", 32'(frame_count), 1);
        check("f1_vcount", 32'(vcount), 0);
        tick(1);
        check("f1_frame_start_low", 32'(frame_start), 0);
        tick(649);
        check("f3_frame_count", 32'(frame_count), 3);
        check("f3_frame_start", 32'(frame_start), 1);

        // Half-rate enable: line_start expected 48 and 98 clks in, 50 apart.
        exp_q.push_back(32'd48);
        exp_q.push_back(32'd98);
        for (int i = 0; i < 110; i++) begin
            enable = (i % 2 == 0);
            tick(1);
            if (line_start) begin
                pulses++;
                if (prev) wide++;
                if (exp_q.size() > 0) check("gated_pulse_index", i, exp_q.pop_front());
                if (prev_i >= 0) check("gated_line_period", i - prev_i, 2 * HT);
                prev_i = i;
            end
            prev = line_start;
        end
        check("gated_pulse_count", pulses, 2);
        check("gated_wide_pulses", wide, 0);
        check("gated_queue_drained", exp_q.size(), 0);

        // Mid-frame reset with enable low: still takes effect.
        enable = 1'b1;
        tick(40);
        check("pre_reset_hcount", 32'(hcount), 20);
        check("pre_reset_vcount", 32'(vcount), 3);
        reset_n = 1'b0;
        enable  = 1'b0;
        tick(1);
        expect_reset_state("midreset");
        reset_n = 1'b1;
        tick(1);
        check("idle_hcount", 32'(hcount), 0);
        enable = 1'b1;
        tick(1);
        check("resume_hcount", 32'(hcount), 1);
        check("resume_vcount", 32'(vcount), 0);
        tick(24);
        check("resume_line_start", 32'(line_start), 1);
        check("resume_frame_start", 32'(frame_start), 0);
        tick(1);
    endtask

    // ---------------- frame_count wrap sequence ----------------
    task automatic run_wrap();
        w_reset_n = 1'b0;
        w_enable  = 1'b1;
        tick(2);
        w_chk     = 1;
        w_reset_n = 1'b1;
        tick(65535);
        check("wrap_fc_max", 32'(w_frame_count), 65535);
        check("wrap_fs_max", 32'(w_frame_start), 1);
        tick(1);
        check("wrap_fc_zero", 32'(w_frame_count), 0);
        check("wrap_fs_zero", 32'(w_frame_start), 1);
        tick(1);
    endtask

    // ---------------- top-level flow and report ----------------
    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        w_reset_n = 1'b0;
        w_enable  = 1'b0;
        fork
            run_main();
            run_wrap();
        join
        m_chk = 0;
        w_chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
